// File: rtl/exe_stage_req_pkg.sv
// Shared definitions for the EXE stage: bundle widths, mem_all bit positions,
// access-size encodings and the data-request FSM states.
package exe_stage_req_pkg;

    localparam int MEM_ALL_W = 8;
    localparam int RF_ALL_W  = 6;
    localparam int CSR_RF_W  = 79;
    localparam int EXC_RF_W  = 7;

    // mem_all = {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
    localparam int MA_MEM_WE = 7;
    localparam int MA_LD_B   = 6;
    localparam int MA_LD_H   = 5;
    localparam int MA_LD_W   = 4;
    localparam int MA_LD_SE  = 3;
    localparam int MA_ST_B   = 2;
    localparam int MA_ST_H   = 1;
    localparam int MA_ST_W   = 0;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_DONE = 1'b1
    } req_state_e;

endpackage

// File: rtl/exe_stage_req_if.sv
// Data SRAM-like request channel between the EXE stage (master) and memory (slave).
interface exe_stage_req_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok
    );

endinterface

// File: rtl/exe_stage_req_store_align.sv
// Combinational store/load alignment: access size, byte strobes, replicated
// store data and the misaligned-access (ALE) flag.
module exe_store_align
    import exe_stage_req_pkg::*;
(
    input  logic [MEM_ALL_W-1:0] mem_all,
    input  logic [31:0]          addr,
    input  logic [31:0]          rkd,
    output logic [1:0]           size,
    output logic [3:0]           wstrb,
    output logic [31:0]          wdata,
    output logic                 ale
);

    logic ld_b, ld_h, ld_w, st_b, st_h, st_w;
    logic unused_mem_bits;

    function automatic logic [3:0] byte_strobe(input logic [1:0] off);
        byte_strobe = 4'b0001 << off;
    endfunction

    function automatic logic [3:0] half_strobe(input logic hi);
        half_strobe = hi ? 4'b1100 : 4'b0011;
    endfunction

    assign ld_b = mem_all[MA_LD_B];
    assign ld_h = mem_all[MA_LD_H];
    assign ld_w = mem_all[MA_LD_W];
    assign st_b = mem_all[MA_ST_B];
    assign st_h = mem_all[MA_ST_H];
    assign st_w = mem_all[MA_ST_W];
    // write enable and sign-extension do not affect alignment
    assign unused_mem_bits = mem_all[MA_MEM_WE] ^ mem_all[MA_LD_SE];

    always_comb begin
        size  = SZ_B;
        wstrb = 4'b0000;
        wdata = rkd;
        if (ld_h | st_h) begin
            size = SZ_H;
        end else if (ld_w | st_w) begin
            size = SZ_W;
        end
        if (st_b) begin
            wstrb = byte_strobe(addr[1:0]);
            wdata = {4{rkd[7:0]}};
        end else if (st_h) begin
            wstrb = half_strobe(addr[1]);
            wdata = {2{rkd[15:0]}};
        end else if (st_w) begin
            wstrb = 4'b1111;
        end
        ale = ((ld_h | st_h) & addr[0]) | ((ld_w | st_w) & (addr[1:0] != 2'b00));
    end

endmodule

// File: rtl/exe_stage_req.sv
// EXE pipeline stage: ID->EXE registers, operand drive to the external ALU,
// data-request issue with misalignment detection, and the EXE->MEM bundle.
module exe_stage_req
    import exe_stage_req_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h1bfffffc
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 id_to_exe_valid,
    output logic                 exe_allowin,
    input  logic [31:0]          id_pc,
    input  logic [31:0]          id_src1,
    input  logic [31:0]          id_src2,
    input  logic [11:0]          id_alu_op,
    input  logic [31:0]          id_rkd_value,
    input  logic                 id_res_from_mem,
    input  logic [MEM_ALL_W-1:0] id_mem_all,
    input  logic [RF_ALL_W-1:0]  id_rf_all,
    input  logic [CSR_RF_W-1:0]  id_csr_rf,
    input  logic [5:0]           id_exc_rf,

    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    output logic [11:0]          alu_op,
    input  logic [31:0]          alu_result,

    input  logic                 mem_allowin,
    output logic                 exe_ready_go,
    output logic                 exe_to_mem_valid,
    output logic [31:0]          exe_pc,
    output logic [31:0]          exe_result,
    output logic [31:0]          exe_rkd_value,
    output logic                 exe_res_from_mem,
    output logic [MEM_ALL_W-1:0] exe_mem_all,
    output logic [RF_ALL_W-1:0]  exe_rf_all,
    output logic [CSR_RF_W-1:0]  exe_csr_rf,
    output logic [EXC_RF_W-1:0]  exe_exc_rf,

    input  logic                 mem_exc_flush,
    input  logic                 wb_exc_flush,
    input  logic                 cancel_exc_ertn,

    exe_stage_req_if.master      data_sram
);

    logic                 exe_valid;
    logic [31:0]          pc_p1;
    logic [31:0]          src1_p1;
    logic [31:0]          src2_p1;
    logic [11:0]          alu_op_p1;
    logic [31:0]          rkd_p1;
    logic                 res_from_mem_p1;
    logic [MEM_ALL_W-1:0] mem_all_p1;
    logic [RF_ALL_W-1:0]  rf_all_p1;
    logic [CSR_RF_W-1:0]  csr_rf_p1;
    logic [5:0]           exc_p1;

    req_state_e state_q, state_d;
    logic       sram_req;
    logic       is_mem;
    logic       no_req;
    logic       ale;
    logic [1:0] al_size;
    logic [3:0] al_wstrb;
    logic [31:0] al_wdata;

    // ---- ID -> EXE register boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_valid       <= 1'b0;
            pc_p1           <= PC_RESET;
            src1_p1         <= '0;
            src2_p1         <= '0;
            alu_op_p1       <= '0;
            rkd_p1          <= '0;
            res_from_mem_p1 <= 1'b0;
            mem_all_p1      <= '0;
            rf_all_p1       <= '0;
            csr_rf_p1       <= '0;
            exc_p1          <= '0;
        end else begin
            if (exe_allowin) begin
                exe_valid <= id_to_exe_valid & ~cancel_exc_ertn;
            end
            if (exe_allowin & id_to_exe_valid) begin
                pc_p1           <= id_pc;
                src1_p1         <= id_src1;
                src2_p1         <= id_src2;
                alu_op_p1       <= id_alu_op;
                rkd_p1          <= id_rkd_value;
                res_from_mem_p1 <= id_res_from_mem;
                mem_all_p1      <= id_mem_all;
                rf_all_p1       <= id_rf_all;
                csr_rf_p1       <= id_csr_rf;
                exc_p1          <= id_exc_rf;
            end
        end
    end

    exe_store_align u_align (
        .mem_all (mem_all_p1),
        .addr    (alu_result),
        .rkd     (rkd_p1),
        .size    (al_size),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ale     (ale)
    );

    assign alu_src1 = src1_p1;
    assign alu_src2 = src2_p1;
    assign alu_op   = alu_op_p1;

    assign exe_exc_rf = {exc_p1[5], exc_p1[4], ale, exc_p1[3:0]};
    assign is_mem     = mem_all_p1[MA_MEM_WE] | res_from_mem_p1;
    // anything older excepting, or this op excepting, suppresses the access
    assign no_req     = ~exe_valid | (|exe_exc_rf) | mem_exc_flush | wb_exc_flush
                        | cancel_exc_ertn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sram_req = 1'b0;
        case (state_q)
            REQ_IDLE: begin
                sram_req = exe_valid & is_mem & ~no_req;
                if (sram_req & data_sram.addr_ok & ~mem_allowin) begin
                    state_d = REQ_DONE;
                end
            end
            REQ_DONE: begin
                if (mem_allowin | cancel_exc_ertn) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    assign exe_ready_go = ~is_mem
                          | (|exe_exc_rf)
                          | mem_exc_flush | wb_exc_flush
                          | (sram_req & data_sram.addr_ok)
                          | (state_q == REQ_DONE);

    assign exe_allowin      = ~exe_valid | (exe_ready_go & mem_allowin) | cancel_exc_ertn;
    assign exe_to_mem_valid = exe_valid & exe_ready_go & ~cancel_exc_ertn;

    // ---- EXE -> MEM bundle ----
    assign exe_pc           = pc_p1;
    assign exe_result       = alu_result;
    assign exe_rkd_value    = rkd_p1;
    assign exe_res_from_mem = res_from_mem_p1;
    assign exe_mem_all      = mem_all_p1;
    assign exe_rf_all       = rf_all_p1 & {RF_ALL_W{exe_valid}};
    assign exe_csr_rf       = csr_rf_p1;

    // request fields come from held registers, so they stay stable until addr_ok
    assign data_sram.req   = sram_req;
    assign data_sram.wr    = mem_all_p1[MA_MEM_WE];
    assign data_sram.size  = al_size;
    assign data_sram.wstrb = al_wstrb;
    assign data_sram.addr  = alu_result;
    assign data_sram.wdata = al_wdata;

endmodule

// File: tb/tb_exe_stage_req.sv
// Directed bench for exe_stage_req: vector table for single-cycle accesses plus
// hand sequences for stall, DONE hold, async reset, cancel and flush.
module tb_exe_stage_req;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_to_exe_valid = 1'b0;
    logic        exe_allowin;
    logic [31:0] id_pc = '0, id_src1 = '0, id_src2 = '0, id_rkd_value = '0;
    logic [11:0] id_alu_op = '0;
    logic        id_res_from_mem = 1'b0;
    logic [7:0]  id_mem_all = '0;
    logic [5:0]  id_rf_all = '0;
    logic [78:0] id_csr_rf = '0;
    logic [5:0]  id_exc_rf = '0;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [11:0] alu_op;
    logic        mem_allowin = 1'b1;
    logic        exe_ready_go, exe_to_mem_valid;
    logic [31:0] exe_pc, exe_result, exe_rkd_value;
    logic        exe_res_from_mem;
    logic [7:0]  exe_mem_all;
    logic [5:0]  exe_rf_all;
    logic [78:0] exe_csr_rf;
    logic [6:0]  exe_exc_rf;
    logic        mem_exc_flush = 1'b0, wb_exc_flush = 1'b0, cancel_exc_ertn = 1'b0;

    exe_stage_req_if dsram();

    // external ALU model: address = src1 + src2
    assign alu_result = alu_src1 + alu_src2;

    exe_stage_req #(.PC_RESET(32'h1bfffffc)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_to_exe_valid  (id_to_exe_valid),
        .exe_allowin      (exe_allowin),
        .id_pc            (id_pc),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_alu_op        (id_alu_op),
        .id_rkd_value     (id_rkd_value),
        .id_res_from_mem  (id_res_from_mem),
        .id_mem_all       (id_mem_all),
        .id_rf_all        (id_rf_all),
        .id_csr_rf        (id_csr_rf),
        .id_exc_rf        (id_exc_rf),
        .alu_src1         (alu_src1),
        .alu_src2         (alu_src2),
        .alu_op           (alu_op),
        .alu_result       (alu_result),
        .mem_allowin      (mem_allowin),
        .exe_ready_go     (exe_ready_go),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_pc           (exe_pc),
        .exe_result       (exe_result),
        .exe_rkd_value    (exe_rkd_value),
        .exe_res_from_mem (exe_res_from_mem),
        .exe_mem_all      (exe_mem_all),
        .exe_rf_all       (exe_rf_all),
        .exe_csr_rf       (exe_csr_rf),
        .exe_exc_rf       (exe_exc_rf),
        .mem_exc_flush    (mem_exc_flush),
        .wb_exc_flush     (wb_exc_flush),
        .cancel_exc_ertn  (cancel_exc_ertn),
        .data_sram        (dsram)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  mem_all;
        logic        res;
        logic [31:0] addr;
        logic [31:0] rkd;
        logic        e_req;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic        chk_wdata;
        logic [31:0] e_wdata;
        logic        e_ale;
    } vec_t;

    vec_t vecs[12];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one instruction for a single edge; EXE must be accepting
    task automatic load(input logic [7:0] mem_all, input logic res, input logic [31:0] addr,
                        input logic [31:0] rkd, input logic [5:0] exc);
        id_to_exe_valid = 1'b1;
        id_pc           = 32'h1c00_0000 + addr;
        id_src1         = addr;
        id_src2         = 32'h0;
        id_alu_op       = 12'h001;
        id_rkd_value    = rkd;
        id_res_from_mem = res;
        id_mem_all      = mem_all;
        id_rf_all       = 6'b1_00101;
        id_exc_rf       = exc;
        step();
        id_to_exe_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"add",     8'h00, 1'b0, 32'h0000_0010, 32'h1234_5678, 0, 0, 2'd0, 4'b0000, 0, 32'h0,          0};
        vecs[1]  = '{"stb_3",   8'h84, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1, 1, 2'd0, 4'b1000, 1, 32'hA5A5_A5A5, 0};
        vecs[2]  = '{"stb_0",   8'h84, 1'b0, 32'h0000_1000, 32'h0000_005A, 1, 1, 2'd0, 4'b0001, 1, 32'h5A5A_5A5A, 0};
        vecs[3]  = '{"sth_hi",  8'h82, 1'b0, 32'h0000_1002, 32'h0000_BEEF, 1, 1, 2'd1, 4'b1100, 1, 32'hBEEF_BEEF, 0};
        vecs[4]  = '{"sth_lo",  8'h82, 1'b0, 32'h0000_1000, 32'h1111_2222, 1, 1, 2'd1, 4'b0011, 1, 32'h2222_2222, 0};
        vecs[5]  = '{"stw",     8'h81, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 1, 1, 2'd2, 4'b1111, 1, 32'hDEAD_BEEF, 0};
        vecs[6]  = '{"ldw",     8'h10, 1'b1, 32'h0000_2004, 32'h0,         1, 0, 2'd2, 4'b0000, 0, 32'h0,          0};
        vecs[7]  = '{"ldb_se",  8'h48, 1'b1, 32'h0000_2003, 32'h0,         1, 0, 2'd0, 4'b0000, 0, 32'h0,          0};
        vecs[8]  = '{"ldh_ale", 8'h20, 1'b1, 32'h0000_2001, 32'h0,         0, 0, 2'd1, 4'b0000, 0, 32'h0,          1};
        vecs[9]  = '{"stw_ale", 8'h81, 1'b0, 32'h0000_1002, 32'h0,         0, 1, 2'd2, 4'b1111, 0, 32'h0,          1};
        vecs[10] = '{"ldh_ok",  8'h20, 1'b1, 32'h0000_2002, 32'h0,         1, 0, 2'd1, 4'b0000, 0, 32'h0,          0};
        vecs[11] = '{"sth_ale", 8'h82, 1'b0, 32'h0000_1001, 32'h0,         0, 1, 2'd1, 4'b0011, 0, 32'h0,          1};

        dsram.addr_ok = 1'b0;

        // reset state
        #12;
        chk("rst_pc",        exe_pc, 32'h1bfffffc);
        chk("rst_req",       {31'b0, dsram.req}, 32'h0);
        chk("rst_to_mem",    {31'b0, exe_to_mem_valid}, 32'h0);
        chk("rst_allowin",   {31'b0, exe_allowin}, 32'h1);
        chk("rst_rf_all",    {26'b0, exe_rf_all}, 32'h0);
        chk("rst_mem_all",   {24'b0, exe_mem_all}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // table: one instruction per pass, addr_ok and mem_allowin high
        for (int i = 0; i < 12; i++) begin
            load(vecs[i].mem_all, vecs[i].res, vecs[i].addr, vecs[i].rkd, 6'b0);
            dsram.addr_ok = 1'b1;
            #1;
            chk({vecs[i].name, "_req"},   {31'b0, dsram.req},   {31'b0, vecs[i].e_req});
            chk({vecs[i].name, "_wr"},    {31'b0, dsram.wr},    {31'b0, vecs[i].e_wr});
            chk({vecs[i].name, "_size"},  {30'b0, dsram.size},  {30'b0, vecs[i].e_size});
            chk({vecs[i].name, "_wstrb"}, {28'b0, dsram.wstrb}, {28'b0, vecs[i].e_wstrb});
            if (vecs[i].chk_wdata) chk({vecs[i].name, "_wdata"}, dsram.wdata, vecs[i].e_wdata);
            chk({vecs[i].name, "_addr"},  dsram.addr, vecs[i].addr);
            chk({vecs[i].name, "_ale"},   {31'b0, exe_exc_rf[4]}, {31'b0, vecs[i].e_ale});
            chk({vecs[i].name, "_rdy"},   {31'b0, exe_ready_go}, 32'h1);
            chk({vecs[i].name, "_tomem"}, {31'b0, exe_to_mem_valid}, 32'h1);
            step();
            dsram.addr_ok = 1'b0;
        end
        chk("table_drained", {31'b0, exe_to_mem_valid}, 32'h0);

        // ld.w stalled three cycles on addr_ok
        load(8'h10, 1'b1, 32'h2000, 32'h0, 6'b0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_req",     {31'b0, dsram.req}, 32'h1);
            chk("stall_addr",    dsram.addr, 32'h2000);
            chk("stall_rdy",     {31'b0, exe_ready_go}, 32'h0);
            chk("stall_allowin", {31'b0, exe_allowin}, 32'h0);
            step();
        end
        chk("stall_rf_all", {26'b0, exe_rf_all}, {26'b0, 6'b1_00101});
        dsram.addr_ok = 1'b1;
        #1;
        chk("stall_ok_rdy",   {31'b0, exe_ready_go}, 32'h1);
        chk("stall_ok_tomem", {31'b0, exe_to_mem_valid}, 32'h1);
        step();
        dsram.addr_ok = 1'b0;

        // st.w accepted while MEM is blocked: DONE holds without re-requesting
        load(8'h81, 1'b0, 32'h1008, 32'hCAFE_F00D, 6'b0);
        mem_allowin   = 1'b0;
        dsram.addr_ok = 1'b1;
        #1;
        chk("done_req0", {31'b0, dsram.req}, 32'h1);
        step();
        for (int c = 0; c < 2; c++) begin
            chk("done_req",     {31'b0, dsram.req}, 32'h0);
            chk("done_rdy",     {31'b0, exe_ready_go}, 32'h1);
            chk("done_tomem",   {31'b0, exe_to_mem_valid}, 32'h1);
            chk("done_allowin", {31'b0, exe_allowin}, 32'h0);
            step();
        end
        dsram.addr_ok = 1'b0;
        mem_allowin   = 1'b1;
        #1;
        chk("done_release", {31'b0, exe_allowin}, 32'h1);
        step();
        chk("done_left", {31'b0, exe_to_mem_valid}, 32'h0);
        // a fresh load after leaving DONE must request again
        load(8'h10, 1'b1, 32'h200C, 32'h0, 6'b0);
        chk("after_done_req", {31'b0, dsram.req}, 32'h1);

        // async reset in the middle of the pending request
        #2;
        reset = 1'b1;
        #1;
        chk("areset_req",   {31'b0, dsram.req}, 32'h0);
        chk("areset_tomem", {31'b0, exe_to_mem_valid}, 32'h0);
        chk("areset_rf",    {26'b0, exe_rf_all}, 32'h0);
        chk("areset_pc",    exe_pc, 32'h1bfffffc);
        @(negedge clk);
        reset = 1'b0;
        step();

        // cancel pulse squashes a pending load
        load(8'h10, 1'b1, 32'h2010, 32'h0, 6'b0);
        cancel_exc_ertn = 1'b1;
        #1;
        chk("cancel_req",     {31'b0, dsram.req}, 32'h0);
        chk("cancel_tomem",   {31'b0, exe_to_mem_valid}, 32'h0);
        chk("cancel_allowin", {31'b0, exe_allowin}, 32'h1);
        step();
        cancel_exc_ertn = 1'b0;
        #1;
        chk("cancel_after_req", {31'b0, dsram.req}, 32'h0);
        chk("cancel_after_rf",  {26'b0, exe_rf_all}, 32'h0);

        // older instruction excepting: no request, op drains
        load(8'h10, 1'b1, 32'h2014, 32'h0, 6'b0);
        mem_exc_flush = 1'b1;
        #1;
        chk("flush_req", {31'b0, dsram.req}, 32'h0);
        chk("flush_rdy", {31'b0, exe_ready_go}, 32'h1);
        step();
        mem_exc_flush = 1'b0;

        // incoming INT exception maps to the top bit and suppresses the access
        load(8'h10, 1'b1, 32'h2018, 32'h0, 6'b100000);
        chk("exc_map", {25'b0, exe_exc_rf}, {25'b0, 7'b1000000});
        chk("exc_req", {31'b0, dsram.req}, 32'h0);
        chk("exc_rdy", {31'b0, exe_ready_go}, 32'h1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exe_stage_req.md
Name: exe_stage_req

Overview:
EXE pipeline stage that sits between ID and MEMstate. It holds the ID→EXE pipeline registers and drives operands to an external combinational ALU. It issues load/store requests on the data SRAM-like request channel and detects misaligned accesses (ALE). It presents the EXE→MEM bundle that MEMstate latches.

Parameters:
- PC_RESET, 32'h1bfffffc: reset value of exe_pc.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_to_exe_valid  in  1  ID payload valid
- exe_allowin  out  1  EXE can accept ID payload
- id_pc  in  32  instruction PC
- id_src1, id_src2  in  32 each  ALU operands
- id_alu_op  in  12  ALU op one-hot
- id_rkd_value  in  32  store data
- id_res_from_mem  in  1  instruction is a load
- id_mem_all  in  8  {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
- id_rf_all  in  6  {rf_we, rf_waddr}
- id_csr_rf  in  79  CSR bundle, passed through
- id_exc_rf  in  6  {INT, ADEF, BRK, INE, SYS, ertn}
- alu_src1, alu_src2  out  32 each  registered operands
- alu_op  out  12  registered op
- alu_result  in  32  combinational ALU result; equals the effective address for memory ops
- mem_allowin  in  1  from MEMstate
- exe_ready_go, exe_to_mem_valid  out  1 each
- exe_pc, exe_result, exe_rkd_value  out  32 each
- exe_res_from_mem  out  1
- exe_mem_all  out  8
- exe_rf_all  out  6  gated by exe_valid
- exe_csr_rf  out  79
- exe_exc_rf  out  7  {INT, ADEF, ALE, BRK, INE, SYS, ertn}
- mem_exc_flush, wb_exc_flush  in  1 each  older instruction excepting
- cancel_exc_ertn  in  1  pipeline flush
- data_sram_req  out  1
- data_sram_wr  out  1
- data_sram_size  out  2  (0 = byte, 1 = half, 2 = word)
- data_sram_wstrb  out  4
- data_sram_addr  out  32
- data_sram_wdata  out  32
- data_sram_addr_ok  in  1

Behaviour:
- Reset (async) values:
  - exe_valid = 0, req_state = IDLE, exe_pc = PC_RESET.
  - All payload registers are 0, so every output derived from them is 0 and data_sram_req = 0.
- Latching:
  - On exe_allowin & id_to_exe_valid, capture all id_* fields and set exe_valid = 1.
  - On exe_allowin & ~id_to_exe_valid, set exe_valid = 0.
  - cancel_exc_ertn clears exe_valid on the next edge and has priority over latching.
- exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin) | cancel_exc_ertn.
- is_mem = mem_we | res_from_mem.
- ALE:
  - Set for (ld_h | st_h) & addr[0].
  - Set for (ld_w | st_w) & (addr[1:0] != 0).
  - exe_exc_rf = {INT, ADEF, ALE, BRK, INE, SYS, ertn}.
- no_req = ~exe_valid | (|exe_exc_rf) | mem_exc_flush | wb_exc_flush | cancel_exc_ertn. A younger instruction never accesses memory behind an excepting one.
- Request FSM (2 states):
  - IDLE: data_sram_req = exe_valid & is_mem & ~no_req.
    - If req & addr_ok and ~mem_allowin, go to DONE.
    - If req & addr_ok and mem_allowin, the payload leaves the stage; stay in IDLE.
  - DONE: data_sram_req = 0; the request is held as accepted. Go to IDLE on mem_allowin or cancel_exc_ertn.
  - Once data_sram_req is asserted, addr, size, wstrb and wdata are held stable until addr_ok.
- exe_ready_go =
  - ~is_mem
  - | (|exe_exc_rf)
  - | mem_exc_flush | wb_exc_flush (the op is squashed; MEM treats it as non-memory via its exc path)
  - | (req & addr_ok)
  - | (req_state == DONE).
- exe_to_mem_valid = exe_valid & exe_ready_go & ~cancel_exc_ertn.
- Request fields:
  - data_sram_wr = mem_we.
  - data_sram_addr = alu_result.
  - size = 0 for ld_b/st_b, 1 for ld_h/st_h, 2 for ld_w/st_w.
  - st_b: wstrb = 4'b0001 << addr[1:0]; wdata = {4{rkd[7:0]}}.
  - st_h: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rkd[15:0]}}.
  - st_w: wstrb = 4'b1111; wdata = rkd.
  - Loads: wstrb = 0.
- Result: exe_result = alu_result (MEM uses it for load byte selection).
- Cancel after addr_ok: the accepted request stays outstanding. MEMstate absorbs its data_ok; this block only clears state.

Decomposition:
- Shared package (cpu_pkg):
  - Bundle widths: MEM_ALL_W = 8, RF_ALL_W = 6, CSR_RF_W = 79, EXC_RF_W = 7.
  - mem_all bit indices.
  - Size encodings SZ_B / SZ_H / SZ_W.
  - FSM state constants.
- Sub-module: exe_store_align (combinational: mem_all, addr, rkd → size, wstrb, wdata, ale).

Test Plan:
- add.w with alu_result = 0x10 → exe_ready_go in the same cycle, data_sram_req = 0, exe_to_mem_valid = 1.
- st.b, addr 0x1003, rkd = 0x000000A5, addr_ok = 1 → req = 1, wr = 1, size = 0, wstrb = 4'b1000, wdata = 0xA5A5A5A5.
- ld.w at 0x2000 with addr_ok low for 3 cycles → req held with addr stable, ready_go = 0 until the addr_ok cycle.
- ld.h at 0x2001 → req never asserted, exe_exc_rf ALE bit = 1, ready_go = 1.
- st.w, addr_ok while mem_allowin = 0 → FSM in DONE, req = 0 with no second request, ready_go = 1; payload leaves when mem_allowin = 1.
- Reset asserted mid-request (async) → exe_valid = 0 and data_sram_req = 0 immediately; cancel_exc_ertn pulse → exe_valid = 0 next edge and no request.
